// File: rtl/uart_receiver.sv
// 8-bit UART receiver with 16x oversampling, optional parity and frame checking.
// Define UART_RX_MAJORITY_VOTE_EN to make every sample point a 2-of-3 vote over recent ticks.
module uart_receiver #(
  parameter int PARITY_EN   = 1,
  parameter int PARITY_TYPE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick16,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EN_L  = (PARITY_EN != 32'sd0);
  localparam logic PAR_ODD_L = (PARITY_TYPE != 32'sd0);

  function automatic logic calc_parity(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t     state_r, state_nxt_s;
  logic       sync1_r, rx_s;
  logic       smp_s;
  logic [3:0] tick_cnt_r, tick_cnt_nxt_s;
  logic [2:0] bit_idx_r, bit_idx_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic       par_smp_r, par_smp_nxt_s;
  logic [7:0] data_nxt_s;
  logic       rx_done_nxt_s, parity_err_nxt_s, frame_err_nxt_s;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_r;

  // Previous two tick samples; the current rx_s completes the 3-deep window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_r <= 2'b11;
    end else if (baud_tick16) begin
      hist_r <= {hist_r[0], rx_s};
    end else begin
      hist_r <= hist_r;
    end
  end

  assign smp_s = maj3(hist_r[1], hist_r[0], rx_s);
`else
  assign smp_s = rx_s;
`endif

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_nxt_s      = state_r;
    tick_cnt_nxt_s   = tick_cnt_r;
    bit_idx_nxt_s    = bit_idx_r;
    shift_nxt_s      = shift_r;
    par_smp_nxt_s    = par_smp_r;
    data_nxt_s       = data_out;
    parity_err_nxt_s = parity_err;
    frame_err_nxt_s  = frame_err;
    rx_done_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nxt_s    = START;
          tick_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (baud_tick16 && (tick_cnt_r == 4'd7)) begin
          if (!smp_s) begin
            state_nxt_s    = DATA;
            tick_cnt_nxt_s = 4'd0;
            bit_idx_nxt_s  = 3'd0;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (baud_tick16) begin
          tick_cnt_nxt_s = tick_cnt_r + 4'd1;
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      DATA: begin
        if (baud_tick16) begin
          tick_cnt_nxt_s = tick_cnt_r + 4'd1;
          if (tick_cnt_r == 4'd15) begin
            shift_nxt_s[bit_idx_r] = smp_s;
            if (bit_idx_r == 3'd7) begin
              state_nxt_s   = PAR_EN_L ? PARITY : STOP;
              bit_idx_nxt_s = 3'd0;
            end else begin
              bit_idx_nxt_s = bit_idx_r + 3'd1;
            end
          end else begin
            shift_nxt_s = shift_r;
          end
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      PARITY: begin
        if (baud_tick16) begin
          tick_cnt_nxt_s = tick_cnt_r + 4'd1;
          if (tick_cnt_r == 4'd15) begin
            par_smp_nxt_s = smp_s;
            state_nxt_s   = STOP;
          end else begin
            par_smp_nxt_s = par_smp_r;
          end
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      STOP: begin
        if (baud_tick16) begin
          tick_cnt_nxt_s = tick_cnt_r + 4'd1;
          if (tick_cnt_r == 4'd15) begin
            data_nxt_s       = shift_r;
            frame_err_nxt_s  = ~smp_s;
            parity_err_nxt_s = PAR_EN_L ? (par_smp_r != calc_parity(shift_r, PAR_ODD_L)) : 1'b0;
            rx_done_nxt_s    = 1'b1;
            state_nxt_s      = IDLE;
          end else begin
            rx_done_nxt_s = 1'b0;
          end
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        tick_cnt_nxt_s = 4'd0;
        bit_idx_nxt_s  = 3'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      tick_cnt_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      par_smp_r  <= 1'b0;
      data_out   <= 8'h00;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      shift_r    <= shift_nxt_s;
      par_smp_r  <= par_smp_nxt_s;
      data_out   <= data_nxt_s;
      rx_done    <= rx_done_nxt_s;
      parity_err <= parity_err_nxt_s;
      frame_err  <= frame_err_nxt_s;
      busy       <= (state_nxt_s != IDLE);
    end
  end

endmodule
